vit_bm_sched: RTL and testbench

- Branch-metric scheduler for the Viterbi decoder.
- Accepts received symbol pairs over a valid/ready handshake and latches each one. Walks every trellis state, one state per cycle, and presents the Hamming branch metrics for input bit 0 and input bit 1 to the ACS array.
- Tracks frame boundaries and pulses frame_done so traceback can start.
- Sits between the demapper/input FIFO and the ACS/path-metric stage.

---
 rtl/vit_bm_sched.sv | 123 ++++++++++++
 tb/tb_vit_bm_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_bm_sched.sv
// Branch-metric scheduler: latches one received pair, then walks every trellis
// state and presents the Hamming metrics for both input bits to the ACS array.
module vit_bm_sched #(
    parameter int             K     = 3,
    parameter logic [K-1:0]   G0    = 3'b111,
    parameter logic [K-1:0]   G1    = 3'b101,
    parameter int             CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       rx_pair,
    input  logic             sym_last,
    output logic             acs_valid,
    input  logic             acs_ready,
    output logic [K-2:0]     acs_state,
    output logic [1:0]       acs_bm0,
    output logic [1:0]       acs_bm1,
    output logic             acs_first,
    output logic             acs_last,
    output logic             acs_sym_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] sym_count,
    output logic [1:0]       fsm_state
);

    localparam int S_W = K - 1;
    localparam logic [S_W-1:0] LAST_S = {S_W{1'b1}};

    // Handshakes: a symbol transfers on a rising edge with sym_valid && sym_ready;
    // a state beat transfers with acs_valid && acs_ready. Outputs hold while stalled.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [S_W-1:0]   s_q, s_n;
    logic [1:0]       rx_q, rx_n;
    logic             last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    // Expected encoder output for branch (s, u) with u as the MSB of the register.
    function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                                 input logic [S_W-1:0] s,
                                                 input logic u);
        logic [K-1:0] x;
        logic [1:0]   d;
        x    = {u, s};
        d[1] = ^(x & G0);
        d[0] = ^(x & G1);
        d    = rx ^ d;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            s_q    <= '0;
            rx_q   <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            s_q    <= s_n;
            rx_q   <= rx_n;
            last_q <= last_n;
            cnt_q  <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        s_n       = s_q;
        rx_n      = rx_q;
        last_n    = last_q;
        cnt_n     = cnt_q;
        sym_ready = 1'b0;
        case (state)
            IDLE: sym_ready = 1'b1;
            RUN: begin
                if (acs_ready) begin
                    if (s_q != LAST_S) begin
                        s_n = s_q + 1'b1;
                    end else if (last_q) begin
                        state_n = DONE;
                    end else begin
                        sym_ready = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        // A load from IDLE or from the last-state handshake looks the same.
        if (sym_valid && sym_ready) begin
            rx_n    = rx_pair;
            last_n  = sym_last;
            s_n     = '0;
            state_n = RUN;
            cnt_n   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign acs_valid    = (state == RUN);
    assign acs_state    = s_q;
    assign acs_bm0      = branch_metric(rx_q, s_q, 1'b0);
    assign acs_bm1      = branch_metric(rx_q, s_q, 1'b1);
    assign acs_first    = (s_q == '0);
    assign acs_last     = (s_q == LAST_S);
    assign acs_sym_last = last_q;
    assign frame_done   = (state == DONE);
    assign sym_count    = cnt_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_vit_bm_sched.sv
// Self-checking bench for vit_bm_sched (K=3 defaults): directed steps, with a
// scoreboard of expected ACS beats filled on each accepted symbol.
module tb_vit_bm_sched;

    logic        clk;
    logic        rst;
    logic        sym_valid;
    logic        sym_ready;
    logic [1:0]  rx_pair;
    logic        sym_last;
    logic        acs_valid;
    logic        acs_ready;
    logic [1:0]  acs_state;
    logic [1:0]  acs_bm0;
    logic [1:0]  acs_bm1;
    logic        acs_first;
    logic        acs_last;
    logic        acs_sym_last;
    logic        frame_done;
    logic [15:0] sym_count;
    logic [1:0]  fsm_state;

    int vectors;
    int miscompares;

    // Beat word: {state[1:0], bm0[1:0], bm1[1:0], first, last, sym_last}
    logic [8:0] exp_q[$];
    logic [8:0] obs;
    logic [8:0] item;
    logic       exp_done;
    logic       done_next;
    logic       exp_rdy;
    int         run_len;
    int         max_run;

    vit_bm_sched dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .rx_pair(rx_pair), .sym_last(sym_last),
        .acs_valid(acs_valid), .acs_ready(acs_ready),
        .acs_state(acs_state), .acs_bm0(acs_bm0), .acs_bm1(acs_bm1),
        .acs_first(acs_first), .acs_last(acs_last),
        .acs_sym_last(acs_sym_last), .frame_done(frame_done),
        .sym_count(sym_count), .fsm_state(fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference encoder for G0=111, G1=101 written out as XOR terms.
    function automatic logic [1:0] ref_bm(input logic [1:0] rx, input logic [1:0] s, input logic u);
        logic e1, e0;
        int   n;
        e1 = u ^ s[1] ^ s[0];
        e0 = u ^ s[0];
        n  = 0;
        if (rx[1] != e1) n++;
        if (rx[0] != e0) n++;
        return n[1:0];
    endfunction

    task automatic push_symbol(input logic [1:0] rx, input logic last);
        for (int s = 0; s < 4; s++) begin
            logic [1:0] sv;
            sv = s[1:0];
            exp_q.push_back({sv, ref_bm(rx, sv, 1'b0), ref_bm(rx, sv, 1'b1),
                             (s == 0), (s == 3), last});
        end
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_next = 1'b0;
            run_len   = 0;
        end else begin
            exp_done  = done_next;
            done_next = 1'b0;
            check("frame_done", frame_done, exp_done);
            exp_rdy = (exp_q.size() == 0 && !exp_done) ||
                      (exp_q.size() == 1 && acs_ready && !exp_q[0][0]);
            check("sym_ready", sym_ready, exp_rdy);
            check("acs_valid", acs_valid, exp_q.size() != 0);
            obs = {acs_state, acs_bm0, acs_bm1, acs_first, acs_last, acs_sym_last};
            if (acs_valid && exp_q.size() != 0) begin
                if (acs_ready) begin
                    item = exp_q.pop_front();
                    check("beat", obs, item);
                    if (item[1] && item[0]) done_next = 1'b1;
                end else begin
                    check("stall_hold", obs, exp_q[0]);
                end
            end
            run_len = acs_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (sym_valid && sym_ready) push_symbol(rx_pair, sym_last);
        end
    end

    // Driver tasks
    task automatic send_sym(input logic [1:0] rx, input logic last, input int cnt);
        int   n;
        logic hs;
        sym_valid = 1'b1;
        rx_pair   = rx;
        sym_last  = last;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = sym_ready;
            n++;
        end
        @(posedge clk);
        #1;
        check("accept_timeout", hs, 1);
        check("sym_count", sym_count, cnt);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (acs_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", acs_valid, 0);
    endtask

    task automatic wait_done();
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(posedge clk);
            #1;
            seen = frame_done;
            n++;
        end
        check("done_timeout", seen, 1);
        check("ready_in_done", sym_ready, 0);
        @(posedge clk);
        #1;
        check("count_cleared", sym_count, 0);
        check("back_to_idle", fsm_state, 0);
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        max_run     = 0;
        run_len     = 0;
        done_next   = 1'b0;
        rst         = 1'b1;
        sym_valid   = 1'b0;
        rx_pair     = 2'b00;
        sym_last    = 1'b0;
        acs_ready   = 1'b1;

        // Reset state
        #3;
        check("rst_acs_valid", acs_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_fsm", fsm_state, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_sym_ready", sym_ready, 1);

        // Single symbol rx=00, not last
        send_sym(2'b00, 1'b0, 1);
        sym_valid = 1'b0;
        wait_idle();
        check("idle_ready", sym_ready, 1);

        // rx=10 closing the frame
        send_sym(2'b10, 1'b1, 2);
        sym_valid = 1'b0;
        wait_done();

        // Back-to-back symbols, sym_valid held high
        max_run = 0;
        send_sym(2'($urandom_range(0, 3)), 1'b0, 1);
        send_sym(2'($urandom_range(0, 3)), 1'b0, 2);
        send_sym(2'($urandom_range(0, 3)), 1'b1, 3);
        sym_valid = 1'b0;
        wait_done();
        check("b2b_no_gap", max_run, 12);

        // Backpressure at s=2
        send_sym(2'($urandom_range(0, 3)), 1'b1, 1);
        sym_valid = 1'b0;
        n = 0;
        while (!(acs_valid && acs_state == 2'd2) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_s2", acs_state, 2);
        acs_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_state", acs_state, 2);
        end
        acs_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resume_s3", acs_state, 3);
        wait_done();

        // Reset in the middle of a symbol
        send_sym(2'($urandom_range(0, 3)), 1'b0, 1);
        sym_valid = 1'b0;
        n = 0;
        while (acs_state != 2'd1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_s1", acs_state, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_acs_valid", acs_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_sym_count", sym_count, 0);
        check("midrst_fsm", fsm_state, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("midrst_no_done", frame_done, 0);
        send_sym(2'($urandom_range(0, 3)), 1'b1, 1);
        sym_valid = 1'b0;
        wait_done();

        repeat (2) @(posedge clk);
        #1 check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
